control_fsm: RTL and testbench



---
 rtl/control_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_control_fsm.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the 16-bit datapath.
//
// Fetches instruction words over a request/ready memory handshake.
// Decodes each word into ALU, register-file and memory controls.
// Latches ALU flags into the PSR and resolves conditional branches
// against it. Owns the program counter.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   mem_*                instruction/data memory handshake
//                        (req/we/addr/wdata out; rdata/ready in)
//   rf_ra, rf_rb         register-file read addresses (ir[11:8], ir[3:0])
//   rf_rdata_a/b         read data, valid one cycle after the address
//   rf_we/wa/wdata       register-file write port
//   alu_opcode,
//   alu_carry_in         ALU control; ALU operands are rf_rdata_a/b
//   alu_result,
//   alu_flags            ALU outputs, flags = {N, Z, F, L, C}
//   pc, psr              architectural program counter and status
//   halted               invalid instruction trapped
module control_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [15:0] rf_wdata,
  output logic [15:0] alu_opcode,
  output logic        alu_carry_in,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags,
  output logic [15:0] pc,
  output logic [4:0]  psr,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_SETI  = 4'hD;

  localparam logic [3:0] EXT_LOAD = 4'h0;
  localparam logic [3:0] EXT_STOR = 4'h4;
  localparam logic [3:0] EXT_ADD  = 4'h5;
  localparam logic [3:0] EXT_ADDC = 4'h7;
  localparam logic [3:0] EXT_CMP  = 4'hB;

  state_t             state, state_next;
  logic [15:0]        ir, ir_next;
  logic [15:0]        pc_next;
  logic [4:0]         psr_next;

  logic [3:0]         major, ext;
  logic               is_alu, is_load, is_stor, is_bcond, is_addc, writes_rf;
  logic signed [15:0] disp;

  // Branch condition evaluated against the latched flags {N, Z, F, L, C}.
  function automatic logic cond_taken(input logic [3:0] cond, input logic [4:0] f);
    logic c, l, o, z, n;
    c = f[0];
    l = f[1];
    o = f[2];
    z = f[3];
    n = f[4];
    case (cond)
      4'h0:    cond_taken = z;
      4'h1:    cond_taken = !z;
      4'h2:    cond_taken = c;
      4'h3:    cond_taken = !c;
      4'h4:    cond_taken = l;
      4'h5:    cond_taken = !l;
      4'h6:    cond_taken = n;
      4'h7:    cond_taken = !n;
      4'h8:    cond_taken = o;
      4'h9:    cond_taken = !o;
      4'hA:    cond_taken = n | z;
      4'hB:    cond_taken = !n & !z;
      4'hC:    cond_taken = l | z;
      4'hD:    cond_taken = !l & !z;
      4'hE:    cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  endfunction

  assign major = ir[15:12];
  assign ext   = ir[7:4];

  assign is_alu    = (major == OP_RTYPE) || (major == OP_ADDI) || (major == OP_SHIFT) ||
                     (major == OP_SUBI)  || (major == OP_CMPI) || (major == OP_SETI);
  assign is_load   = (major == OP_MEM) && (ext == EXT_LOAD);
  assign is_stor   = (major == OP_MEM) && (ext == EXT_STOR);
  assign is_bcond  = (major == OP_BCOND);
  assign is_addc   = (major == OP_RTYPE) && (ext == EXT_ADDC);
  // Compares only update flags; they never write a register.
  assign writes_rf = !(((major == OP_RTYPE) && (ext == EXT_CMP)) || (major == OP_CMPI));

  assign disp = {{8{ir[7]}}, ir[7:0]};

  // Register addresses follow ir from DECODE onward, so the read data is
  // valid by EXECUTE and stays valid through MEM.
  assign rf_ra = ir[11:8];
  assign rf_rb = ir[3:0];
  assign rf_wa = ir[11:8];

  // ADDC is presented to the ALU as ADD with the latched carry fed in.
  assign alu_opcode   = is_addc ? {ir[15:8], EXT_ADD, ir[3:0]} : ir;
  assign alu_carry_in = is_addc & psr[0];

  assign halted = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      psr   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      psr   <= psr_next;
    end
  end

  always_comb begin
    state_next = state;
    ir_next    = ir;
    pc_next    = pc;
    psr_next   = psr;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    mem_wdata  = rf_rdata_a;
    rf_we      = 1'b0;
    rf_wdata   = alu_result;

    case (state)
      // FETCH: read instruction at pc, hold request until ready.
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_next    = mem_rdata;
          state_next = S_DECODE;
        end
      end

      // DECODE: register addresses presented; read data arrives next cycle.
      S_DECODE: state_next = S_EXECUTE;

      // EXECUTE: ALU result and flags are consumed combinationally.
      S_EXECUTE: begin
        if (is_alu) begin
          rf_we      = writes_rf;
          psr_next   = alu_flags;
          pc_next    = pc + 16'd1;
          state_next = S_FETCH;
        end else if (is_bcond) begin
          pc_next    = cond_taken(ir[11:8], psr) ? pc + $unsigned(disp) : pc + 16'd1;
          state_next = S_FETCH;
        end else if (is_load || is_stor) begin
          state_next = S_MEM;
        end else begin
          state_next = S_HALT;
        end
      end

      // MEM: data access addressed by Rsrc; loads write back on the ready cycle.
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_stor;
        mem_addr = rf_rdata_b;
        rf_wdata = mem_rdata;
        if (mem_ready) begin
          rf_we      = is_load;
          pc_next    = pc + 16'd1;
          state_next = S_FETCH;
        end
      end

      // HALT: absorbing; pc keeps pointing at the offending word.
      S_HALT: state_next = S_HALT;

      default: state_next = S_FETCH;
    endcase

    // Reset aborts any in-flight access in the same cycle.
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      rf_we   = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed bench for control_fsm.
// Drives memory, register-file and ALU responses by hand each cycle and
// checks strobes, write-back, pc and psr against hand-computed values.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [3:0]  rf_ra;
  logic [3:0]  rf_rb;
  logic [15:0] rf_rdata_a;
  logic [15:0] rf_rdata_b;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [15:0] rf_wdata;
  logic [15:0] alu_opcode;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [15:0] pc;
  logic [4:0]  psr;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  control_fsm #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .rf_ra        (rf_ra),
    .rf_rb        (rf_rb),
    .rf_rdata_a   (rf_rdata_a),
    .rf_rdata_b   (rf_rdata_b),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wdata     (rf_wdata),
    .alu_opcode   (alu_opcode),
    .alu_carry_in (alu_carry_in),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .pc           (pc),
    .psr          (psr),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs FETCH (zero wait states) and DECODE; returns at the start of EXECUTE.
  task automatic fetch_decode(input logic [15:0] addr, input logic [15:0] word);
    mem_ready = 1'b1;
    mem_rdata = word;
    #1;
    chk("fetch_req", mem_req, 1'b1);
    chk("fetch_we", mem_we, 1'b0);
    chk("fetch_addr", mem_addr, addr);
    chk("fetch_rf_we", rf_we, 1'b0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("decode_req", mem_req, 1'b0);
    chk("decode_rf_we", rf_we, 1'b0);
    chk("decode_ra", rf_ra, word[11:8]);
    chk("decode_rb", rf_rb, word[3:0]);
    tick();
  endtask

  task automatic alu_step(input logic [15:0] addr, input logic [15:0] word,
                          input logic [15:0] want_op, input logic want_cin,
                          input logic [15:0] result, input logic [4:0] flags,
                          input logic want_we);
    fetch_decode(addr, word);
    alu_result = result;
    alu_flags  = flags;
    #1;
    chk("exe_opcode", alu_opcode, want_op);
    chk("exe_carry_in", alu_carry_in, want_cin);
    chk("exe_rf_we", rf_we, want_we);
    chk("exe_rf_wa", rf_wa, word[11:8]);
    chk("exe_rf_wdata", rf_wdata, result);
    chk("exe_mem_req", mem_req, 1'b0);
    tick();
  endtask

  // Live ALU flags are driven to the complement of psr so a branch that
  // looked at them instead of psr would go the wrong way.
  task automatic br_step(input logic [15:0] addr, input logic [15:0] word);
    fetch_decode(addr, word);
    alu_flags = ~psr;
    #1;
    chk("br_rf_we", rf_we, 1'b0);
    chk("br_mem_req", mem_req, 1'b0);
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    mem_rdata  = 16'h0000;
    mem_ready  = 1'b0;
    rf_rdata_a = 16'h0000;
    rf_rdata_b = 16'h0000;
    alu_result = 16'h0000;
    alu_flags  = 5'b00000;
    tick();
    tick();

    // Strobes stay low under reset even with mem_ready high.
    mem_ready = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_psr", psr, 5'b00000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_ir", alu_opcode, 16'h0000);
    mem_ready = 1'b0;
    reset     = 1'b0;

    // ADDI R1,#3 with R1=5 -> result 8.
    rf_rdata_a = 16'h0005;
    alu_step(16'h0000, 16'h5103, 16'h5103, 1'b0, 16'h0008, 5'b10001, 1'b1);
    chk("addi_pc", pc, 16'h0001);
    chk("addi_psr", psr, 5'b10001);

    // CMP sets Z, BEQ +4 taken.
    alu_step(16'h0001, 16'h02B3, 16'h02B3, 1'b0, 16'h1234, 5'b01000, 1'b0);
    chk("cmp_pc", pc, 16'h0002);
    chk("cmp_psr", psr, 5'b01000);
    br_step(16'h0002, 16'hC004);
    chk("beq_taken_pc", pc, 16'h0006);
    chk("beq_psr_kept", psr, 5'b01000);

    // CMP clears flags, BEQ +4 not taken.
    alu_step(16'h0006, 16'h02B3, 16'h02B3, 1'b0, 16'h0000, 5'b00000, 1'b0);
    chk("cmp2_psr", psr, 5'b00000);
    br_step(16'h0007, 16'hC004);
    chk("beq_not_taken_pc", pc, 16'h0008);

    // Unconditional backward branches, including wrap below zero.
    br_step(16'h0008, 16'hCEFC);
    chk("buc_m4_pc", pc, 16'h0004);
    br_step(16'h0004, 16'hCE80);
    chk("buc_wrap_pc", pc, 16'hFF84);
    br_step(16'hFF84, 16'hCF05);
    chk("bnv_pc", pc, 16'hFF85);
    br_step(16'hFF85, 16'hCB02);
    chk("bgt_pc", pc, 16'hFF87);

    // STOR R2 -> mem[R3] with three wait states.
    fetch_decode(16'hFF87, 16'h4243);
    rf_rdata_a = 16'hBEEF;
    rf_rdata_b = 16'h0100;
    mem_ready  = 1'b1;
    #1;
    chk("stor_exe_req", mem_req, 1'b0);
    chk("stor_exe_rf_we", rf_we, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk("stor_req", mem_req, 1'b1);
      chk("stor_we", mem_we, 1'b1);
      chk("stor_addr", mem_addr, 16'h0100);
      chk("stor_wdata", mem_wdata, 16'hBEEF);
      chk("stor_rf_we", rf_we, 1'b0);
      chk("stor_pc_hold", pc, 16'hFF87);
      tick();
    end
    mem_ready = 1'b0;
    #1;
    chk("stor_pc", pc, 16'hFF88);
    chk("stor_psr_kept", psr, 5'b00000);
    chk("post_stor_fetch_we", mem_we, 1'b0);
    chk("post_stor_fetch_addr", mem_addr, 16'hFF88);

    // SUBI sets carry, then ADDC uses it and ADD ignores it.
    alu_step(16'hFF88, 16'h9101, 16'h9101, 1'b0, 16'h0004, 5'b00001, 1'b1);
    chk("subi_psr", psr, 5'b00001);
    alu_step(16'hFF89, 16'h0172, 16'h0152, 1'b1, 16'h0009, 5'b00001, 1'b1);
    chk("addc_pc", pc, 16'hFF8A);
    alu_step(16'hFF8A, 16'h0152, 16'h0152, 1'b0, 16'h0007, 5'b00000, 1'b1);
    chk("add_psr", psr, 5'b00000);

    // Invalid word traps and stays trapped.
    fetch_decode(16'hFF8B, 16'hF000);
    #1;
    chk("inv_exe_rf_we", rf_we, 1'b0);
    chk("inv_exe_halted", halted, 1'b0);
    tick();
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("halt_flag", halted, 1'b1);
      chk("halt_mem_req", mem_req, 1'b0);
      chk("halt_rf_we", rf_we, 1'b0);
      chk("halt_pc", pc, 16'hFF8B);
      tick();
    end
    mem_ready = 1'b0;
    reset     = 1'b1;
    tick();
    chk("halt_rst_pc", pc, 16'h0000);
    chk("halt_rst_halted", halted, 1'b0);
    reset = 1'b0;

    // LOAD R1 <- mem[R3] with one wait state.
    fetch_decode(16'h0000, 16'h4103);
    rf_rdata_b = 16'h0200;
    tick();
    #1;
    chk("load_req", mem_req, 1'b1);
    chk("load_we", mem_we, 1'b0);
    chk("load_addr", mem_addr, 16'h0200);
    chk("load_wait_rf_we", rf_we, 1'b0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 16'h1234;
    #1;
    chk("load_rf_we", rf_we, 1'b1);
    chk("load_rf_wa", rf_wa, 4'h1);
    chk("load_rf_wdata", rf_wdata, 16'h1234);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("load_pc", pc, 16'h0001);
    chk("load_rf_we_once", rf_we, 1'b0);

    // LOAD aborted by reset while waiting in MEM.
    fetch_decode(16'h0001, 16'h4103);
    tick();
    #1;
    chk("abort_pre_req", mem_req, 1'b1);
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'h5555;
    #1;
    chk("abort_req", mem_req, 1'b0);
    chk("abort_rf_we", rf_we, 1'b0);
    chk("abort_we", mem_we, 1'b0);
    tick();
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("abort_pc", pc, 16'h0000);
    chk("abort_refetch_req", mem_req, 1'b1);
    chk("abort_refetch_addr", mem_addr, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
